// File: rtl/accel_spi_ctrl_if.sv
// rtl/accel_spi_ctrl_if.sv - host-side request/response bundle for accel_spi_ctrl
// master: drives start, wr, addr, wr_data, rd_len; observes busy, done, rd_data, rd_valid
// slave : the controller side of the same signals
interface accel_spi_ctrl_if;
    logic       start;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic [2:0] rd_len;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output start, wr, addr, wr_data, rd_len,
        input  busy, done, rd_data, rd_valid
    );

    modport slave (
        input  start, wr, addr, wr_data, rd_len,
        output busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/accel_spi_ctrl.sv
// rtl/accel_spi_ctrl.sv - SPI mode-0 master for accelerometer register write / burst read
// Ports: clk, rstn (sync, active-low); host (accel_spi_ctrl_if.slave) request/response;
//        cs_n, sclk, mosi, miso SPI pins; sr_enable, sr_direction, sr_data drive the
//        external 8-bit receive shift register whose parallel value returns on sr_out.
module accel_spi_ctrl #(
    parameter int CLK_HALF = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    accel_spi_ctrl_if.slave         host,
    output logic                    cs_n,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic                    sr_enable,
    output logic                    sr_direction,
    output logic                    sr_data,
    input  logic [7:0]              sr_out
);
    localparam logic [7:0] HALF_M1 = 8'(CLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_SCLK_HI, S_SCLK_LO, S_TRAIL, S_GAP
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] hcnt;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [2:0] last_byte;
    logic       last_bit;
    logic       wr_q;
    logic [7:0] addr_q;
    logic [7:0] wr_data_q;
    logic       mosi_q;
    logic       done_q;
    logic       sr_en_q;
    logic       sr_data_q;
    logic       rd_tag;
    logic       rd_tag_d;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;

    logic       phase_end;
    logic [2:0] len_eff;
    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;

    // Frame byte lookup: 0 = command, 1 = address, 2.. = write data or read dummies.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic w,
                                              input logic [7:0] a, input logic [7:0] d);
        if (idx == 3'd0)      return w ? 8'h0A : 8'h0B;
        else if (idx == 3'd1) return a;
        else                  return w ? d : 8'h00;
    endfunction

    always_comb begin
        phase_end = (hcnt == HALF_M1);
        len_eff   = (host.rd_len == 3'd0) ? 3'd1 :
                    (host.rd_len == 3'd7) ? 3'd6 : host.rd_len;
        cur_byte  = frame_byte(byte_cnt, wr_q, addr_q, wr_data_q);
        nxt_byte  = frame_byte(3'(byte_cnt + 3'd1), wr_q, addr_q, wr_data_q);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (host.start) state_nxt = S_LEAD;
            S_LEAD:    if (phase_end)  state_nxt = S_SCLK_HI;
            S_SCLK_HI: if (phase_end)  state_nxt = S_SCLK_LO;
            S_SCLK_LO: if (phase_end)  state_nxt = last_bit ? S_TRAIL : S_SCLK_HI;
            S_TRAIL:   if (phase_end)  state_nxt = S_GAP;
            S_GAP:     if (phase_end)  state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            hcnt       <= 8'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            last_byte  <= 3'd0;
            last_bit   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 8'h00;
            wr_data_q  <= 8'h00;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            sr_en_q    <= 1'b0;
            sr_data_q  <= 1'b0;
            rd_tag     <= 1'b0;
            rd_tag_d   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state  <= state_nxt;
            hcnt   <= (state == S_IDLE || state_nxt != state) ? 8'd0 : 8'(hcnt + 8'd1);
            done_q <= (state == S_GAP) && (state_nxt == S_IDLE);

            if (state == S_IDLE && host.start) begin
                wr_q      <= host.wr;
                addr_q    <= host.addr;
                wr_data_q <= host.wr_data;
                bit_cnt   <= 3'd7;
                byte_cnt  <= 3'd0;
                last_bit  <= 1'b0;
                last_byte <= host.wr ? 3'd2 : 3'(3'd1 + len_eff);
                mosi_q    <= frame_byte(3'd0, host.wr, host.addr, host.wr_data) >> 7 != 8'd0;
            end

            // Falling SCLK edge: advance to the next frame bit; the final bit holds.
            if (state == S_SCLK_HI && state_nxt == S_SCLK_LO) begin
                if (bit_cnt != 3'd0) begin
                    bit_cnt <= bit_cnt - 3'd1;
                    mosi_q  <= cur_byte[bit_cnt - 3'd1];
                end else if (byte_cnt != last_byte) begin
                    byte_cnt <= byte_cnt + 3'd1;
                    bit_cnt  <= 3'd7;
                    mosi_q   <= nxt_byte[7];
                end else begin
                    last_bit <= 1'b1;
                end
            end

            if (state_nxt == S_GAP && state != S_GAP) mosi_q <= 1'b0;

            // Rising SCLK edge: shift miso into the external register. The bit-0
            // sample of a read data byte is tagged so the completed byte is picked
            // up once the external register has shifted it in.
            if (state_nxt == S_SCLK_HI && state != S_SCLK_HI) begin
                sr_en_q   <= 1'b1;
                sr_data_q <= miso;
                rd_tag    <= !wr_q && (byte_cnt >= 3'd2) && (bit_cnt == 3'd0);
            end else begin
                sr_en_q <= 1'b0;
                rd_tag  <= 1'b0;
            end

            rd_tag_d   <= rd_tag;
            rd_valid_q <= rd_tag_d;
            if (rd_tag_d) rd_data_q <= sr_out;
        end
    end

    assign cs_n          = (state == S_IDLE) || (state == S_GAP);
    assign sclk          = (state == S_SCLK_HI);
    assign mosi          = mosi_q;
    assign sr_enable     = sr_en_q;
    assign sr_direction  = 1'b0;
    assign sr_data       = sr_data_q;
    assign host.busy     = (state != S_IDLE);
    assign host.done     = done_q;
    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_accel_spi_ctrl.sv
// tb/tb_accel_spi_ctrl.sv - directed self-checking bench for accel_spi_ctrl (CLK_HALF 2 and 8)
module tb_accel_spi_ctrl;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    accel_spi_ctrl_if hf ();
    accel_spi_ctrl_if hs ();

    logic f_cs_n, f_sclk, f_mosi_pin, f_miso, f_sr_en, f_sr_dir, f_sr_data;
    logic s_cs_n, s_sclk, s_mosi_pin, s_miso, s_sr_en, s_sr_dir, s_sr_data;
    logic [7:0] f_sr, s_sr;

    accel_spi_ctrl #(.CLK_HALF(2)) u_fast (
        .clk(clk), .rstn(rstn), .host(hf),
        .cs_n(f_cs_n), .sclk(f_sclk), .mosi(f_mosi_pin), .miso(f_miso),
        .sr_enable(f_sr_en), .sr_direction(f_sr_dir), .sr_data(f_sr_data), .sr_out(f_sr)
    );

    accel_spi_ctrl #(.CLK_HALF(8)) u_slow (
        .clk(clk), .rstn(rstn), .host(hs),
        .cs_n(s_cs_n), .sclk(s_sclk), .mosi(s_mosi_pin), .miso(s_miso),
        .sr_enable(s_sr_en), .sr_direction(s_sr_dir), .sr_data(s_sr_data), .sr_out(s_sr)
    );

    // External receive shift registers (shift toward MSB).
    always @(posedge clk) begin
        if (!rstn) begin
            f_sr <= 8'h00;
            s_sr <= 8'h00;
        end else begin
            if (f_sr_en) f_sr <= {f_sr[6:0], f_sr_data};
            if (s_sr_en) s_sr <= {s_sr[6:0], s_sr_data};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Fast-DUT monitor and SPI slave
    logic [7:0]  resp [0:7];
    logic [63:0] f_mosi;
    logic [7:0]  f_rv [0:7];
    int f_mosi_cnt, f_sr_cnt, f_sr_cyc, f_rv_cnt, f_rv_bad, f_done_cnt, f_idx;
    logic f_prev_sclk = 1'b0;

    // Slow-DUT monitor
    logic [63:0] s_mosi;
    int s_rise, s_run, s_bad;
    logic s_prev_sclk = 1'b0;
    logic s_prev_mosi = 1'b0;

    task automatic clear_mon();
        f_mosi = 64'd0; f_mosi_cnt = 0; f_sr_cnt = 0; f_sr_cyc = 0;
        f_rv_cnt = 0; f_rv_bad = 0; f_done_cnt = 0;
        for (int i = 0; i < 8; i++) f_rv[i] = 8'h00;
        s_mosi = 64'd0; s_rise = 0; s_run = 0; s_bad = 0;
    endtask

    always @(negedge clk) begin : fast_mon
        logic [7:0] b;
        int k;
        if (f_sr_en) begin
            f_sr_cnt++;
            f_sr_cyc = cyc;
        end
        if (hf.rd_valid) begin
            if (f_rv_cnt < 8) f_rv[f_rv_cnt] = hf.rd_data;
            f_rv_cnt++;
            if (cyc - f_sr_cyc != 2 || f_sr_cnt % 8 != 0) f_rv_bad++;
        end
        if (f_sclk && !f_prev_sclk) begin
            f_mosi = {f_mosi[62:0], f_mosi_pin};
            f_mosi_cnt++;
        end
        if (hf.done) f_done_cnt++;
        if (f_cs_n) f_idx = 0;
        else if (!f_sclk && f_prev_sclk) f_idx++;
        k = f_idx / 8;
        b = (k < 2 || k > 9) ? 8'h00 : resp[k - 2];
        f_miso = b[7 - (f_idx % 8)];
        f_prev_sclk = f_sclk;
    end

    always @(negedge clk) begin : slow_mon
        if (s_cs_n) begin
            s_run = 0;
        end else if (s_sclk != s_prev_sclk) begin
            if (s_run != 8) s_bad++;
            if (s_sclk) begin
                if (s_mosi_pin != s_prev_mosi) s_bad++;
                s_mosi = {s_mosi[62:0], s_mosi_pin};
                s_rise++;
            end
            s_run = 1;
        end else begin
            s_run++;
        end
        s_prev_sclk = s_sclk;
        s_prev_mosi = s_mosi_pin;
    end

    int start_cyc;

    task automatic drive_f(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [2:0] len);
        hf.wr = w; hf.addr = a; hf.wr_data = d; hf.rd_len = len; hf.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hf.start = 1'b0;
    endtask

    task automatic wait_done_f(input bit poke, output int rel);
        rel = -1;
        for (int k = 0; k < 2000 && rel < 0; k++) begin
            @(negedge clk);
            if (poke && k == 20) hf.start = 1'b1;
            if (poke && k == 21) hf.start = 1'b0;
            if (hf.done) rel = cyc - start_cyc + 1;
        end
    endtask

    task automatic run_f(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [2:0] len, input bit poke, output int rel);
        @(negedge clk);
        clear_mon();
        drive_f(w, a, d, len);
        wait_done_f(poke, rel);
        repeat (20) @(negedge clk);
    endtask

    int rel;

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 8'h11 + 8'(i);
        f_idx = 0;
        f_miso = 1'b0;
        s_miso = 1'b0;
        clear_mon();
        hf.start = 1'b0; hf.wr = 1'b0; hf.addr = 8'h00; hf.wr_data = 8'h00; hf.rd_len = 3'd0;
        hs.start = 1'b0; hs.wr = 1'b0; hs.addr = 8'h00; hs.wr_data = 8'h00; hs.rd_len = 3'd0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        hf.start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs_n", f_cs_n, 1'b1);
        check("rst_outs", {f_sclk, f_mosi_pin, hf.busy, hf.done, hf.rd_valid, f_sr_en, f_sr_data},
              7'b0);
        check("rst_rd_data", hf.rd_data, 8'h00);
        check("rst_sr_dir", f_sr_dir, 1'b0);
        hf.start = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_ignored", hf.busy, 1'b0);

        // Register write 0x2D <- 0x02
        run_f(1'b1, 8'h2D, 8'h02, 3'd0, 1'b0, rel);
        check("wr_done_cycle", 64'(rel), 64'd103);
        check("wr_mosi", f_mosi, 64'h0A2D02);
        check("wr_bits", 64'(f_mosi_cnt), 64'd24);
        check("wr_sr_en", 64'(f_sr_cnt), 64'd24);
        check("wr_no_rv", 64'(f_rv_cnt), 64'd0);
        check("wr_done_cnt", 64'(f_done_cnt), 64'd1);

        // Burst read of 6 bytes from 0x0E
        run_f(1'b0, 8'h0E, 8'h00, 3'd6, 1'b0, rel);
        check("rd6_done_cycle", 64'(rel), 64'd263);
        check("rd6_mosi", f_mosi, 64'h0B0E000000000000);
        check("rd6_rv_cnt", 64'(f_rv_cnt), 64'd6);
        check("rd6_rv_timing", 64'(f_rv_bad), 64'd0);
        for (int i = 0; i < 6; i++)
            check($sformatf("rd6_byte%0d", i), f_rv[i], 8'h11 + 8'(i));
        check("rd6_hold", hf.rd_data, 8'h16);

        // Length clamps
        run_f(1'b0, 8'h0F, 8'h00, 3'd0, 1'b0, rel);
        check("len0_done", 64'(rel), 64'd103);
        check("len0_rv_cnt", 64'(f_rv_cnt), 64'd1);
        check("len0_byte", f_rv[0], 8'h11);
        run_f(1'b0, 8'h0F, 8'h00, 3'd7, 1'b0, rel);
        check("len7_done", 64'(rel), 64'd263);
        check("len7_rv_cnt", 64'(f_rv_cnt), 64'd6);

        // Start while busy is ignored
        run_f(1'b0, 8'h20, 8'h00, 3'd2, 1'b1, rel);
        check("poke_done", 64'(rel), 64'd135);
        check("poke_done_cnt", 64'(f_done_cnt), 64'd1);
        check("poke_idle", hf.busy, 1'b0);
        check("poke_rv_cnt", 64'(f_rv_cnt), 64'd2);

        // Start in the done cycle
        @(negedge clk);
        clear_mon();
        drive_f(1'b0, 8'h30, 8'h00, 3'd1);
        wait_done_f(1'b0, rel);
        check("b2b_first_done", 64'(rel), 64'd103);
        hf.wr = 1'b1; hf.addr = 8'h55; hf.wr_data = 8'hA5; hf.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hf.start = 1'b0;
        check("b2b_lead", {f_cs_n, hf.busy, f_sclk}, 3'b010);
        wait_done_f(1'b0, rel);
        repeat (5) @(negedge clk);
        check("b2b_second_done", 64'(rel), 64'd103);
        check("b2b_mosi", f_mosi[23:0], 24'h0A55A5);
        check("b2b_done_cnt", 64'(f_done_cnt), 64'd2);
        check("b2b_rv_cnt", 64'(f_rv_cnt), 64'd1);

        // Reset during SCLK_HI of the address byte
        @(negedge clk);
        clear_mon();
        drive_f(1'b1, 8'h2D, 8'h02, 3'd0);
        repeat (36) @(negedge clk);
        check("abort_in_hi", f_sclk, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_pins", {f_cs_n, f_sclk, hf.busy, hf.done}, 4'b1000);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(f_done_cnt), 64'd0);
        run_f(1'b1, 8'h2D, 8'h02, 3'd0, 1'b0, rel);
        check("abort_rerun_done", 64'(rel), 64'd103);
        check("abort_rerun_mosi", f_mosi, 64'h0A2D02);

        // Slow DUT timing: CLK_HALF = 8
        @(negedge clk);
        clear_mon();
        hs.wr = 1'b1; hs.addr = 8'h3C; hs.wr_data = 8'hC3; hs.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hs.start = 1'b0;
        rel = -1;
        for (int k = 0; k < 2000 && rel < 0; k++) begin
            @(negedge clk);
            if (hs.done) rel = cyc - start_cyc + 1;
        end
        check("slow_done", 64'(rel), 64'd409);
        check("slow_phase_bad", 64'(s_bad), 64'd0);
        check("slow_rises", 64'(s_rise), 64'd24);
        check("slow_mosi", s_mosi, 64'h0A3CC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
